// File: rtl/fpu_imem_responder.sv
// Instruction-memory responder for the FPU control FSM.
// A sequential loader fills a word store, and a level on load_en commits it.
// While READY, each one-cycle mem_activation returns the addressed word one clock later.
// The word is then held until the next fetch, a reload, or reset.
// A fetch that is misaligned, outside the store, or past the loaded program returns
// HALT_WORD with fetch_err set.
module fpu_imem_responder #(
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'h0000_0010
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              load_en,
  input  logic              load_wr,
  input  logic [31:0]       load_data,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              load_overflow,
  input  logic              mem_activation,
  input  logic [31:0]       pc,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOADING = 2'b01,
    READY   = 2'b10
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state;
  logic [ADDR_W:0]     wr_ptr;
  logic [31:0]         mem [DEPTH];

  logic [ADDR_W-1:0]   fetch_idx;
  logic                store_full;
  logic                mem_we;

  // A fetch is rejected when it is not word aligned.
  // It is also rejected when its upper bits fall outside the store, or when it
  // lands past the committed program.
  function automatic logic fetch_is_err(input logic [31:0]     addr,
                                        input logic [ADDR_W:0] count);
    logic [ADDR_W:0] idx_ext;
    idx_ext = {1'b0, addr[ADDR_W+1:2]};
    return (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0) || (idx_ext >= count);
  endfunction

  assign fetch_idx  = pc[ADDR_W+1:2];
  assign store_full = (wr_ptr == DEPTH_C);
  assign mem_we     = (state == LOADING) && load_en && load_wr && !store_full;
  assign load_done  = (state == READY);

  // Storage array: written only while loading, so reads and writes never overlap.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= load_data;
  end

  // Load/fetch control FSM with registered fetch response.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      load_count    <= '0;
      load_overflow <= 1'b0;
      instruction   <= '0;
      instr_valid   <= 1'b0;
      fetch_err     <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) begin
            state         <= LOADING;
            wr_ptr        <= '0;
            load_overflow <= 1'b0;
          end
        end
        LOADING: begin
          if (!load_en) begin
            // A write strobe on the commit cycle is ignored.
            load_count <= wr_ptr;
            state      <= READY;
          end else if (load_wr) begin
            if (!store_full) wr_ptr        <= wr_ptr + PTR_ONE;
            else             load_overflow <= 1'b1;
          end
        end
        READY: begin
          if (load_en) begin
            // A reload wins over a fetch in the same cycle; the fetch is dropped.
            state         <= LOADING;
            wr_ptr        <= '0;
            instruction   <= '0;
            load_overflow <= 1'b0;
          end else if (mem_activation) begin
            instr_valid <= 1'b1;
            if (fetch_is_err(pc, load_count)) begin
              instruction <= HALT_WORD;
              fetch_err   <= 1'b1;
            end else begin
              instruction <= mem[fetch_idx];
              fetch_err   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_imem_responder.sv
// Directed bench for fpu_imem_responder: load, fetch, overflow, back-to-back,
// reload collision and asynchronous reset scenarios.
module tb_fpu_imem_responder;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam logic [31:0] HALT = 32'h0000_0010;

  logic              clk;
  logic              rst_l;
  logic              load_en;
  logic              load_wr;
  logic [31:0]       load_data;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              load_overflow;
  logic              mem_activation;
  logic [31:0]       pc;
  logic [31:0]       instruction;
  logic              instr_valid;
  logic              fetch_err;

  int n_cmp = 0;
  int n_err = 0;

  fpu_imem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .load_en        (load_en),
    .load_wr        (load_wr),
    .load_data      (load_data),
    .load_done      (load_done),
    .load_count     (load_count),
    .load_overflow  (load_overflow),
    .mem_activation (mem_activation),
    .pc             (pc),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are stable 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle fetch; after return the response cycle is visible.
  task automatic fetch(input logic [31:0] addr);
    mem_activation = 1'b1;
    pc = addr;
    tick();
    mem_activation = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] word, input logic err);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instruction, word);
    check({tag, "_err"},   {31'd0, fetch_err}, {31'd0, err});
  endtask

  initial begin
    rst_l = 1'b0; load_en = 1'b0; load_wr = 1'b0; load_data = '0;
    mem_activation = 1'b0; pc = '0;
    tick(); tick();

    // Reset state
    check("rst_done",     {31'd0, load_done}, 32'd0);
    check("rst_count",    {23'd0, load_count}, 32'd0);
    check("rst_ovf",      {31'd0, load_overflow}, 32'd0);
    check("rst_instr",    instruction, 32'd0);
    check("rst_valid",    {31'd0, instr_valid}, 32'd0);
    check("rst_err",      {31'd0, fetch_err}, 32'd0);
    rst_l = 1'b1;
    tick();

    // Load three words
    load_en = 1'b1; tick();
    load_wr = 1'b1;
    load_data = 32'hA000_0001; tick();
    load_data = 32'hA000_0002; tick();
    load_data = 32'hA000_0003; tick();
    load_wr = 1'b0; load_en = 1'b0; tick();
    check("ld3_done",  {31'd0, load_done}, 32'd1);
    check("ld3_count", {23'd0, load_count}, 32'd3);
    check("ld3_ovf",   {31'd0, load_overflow}, 32'd0);

    fetch(32'h4);
    check_resp("f4", 32'hA000_0002, 1'b0);
    tick();
    check("f4_pulse_end", {31'd0, instr_valid}, 32'd0);
    check("f4_hold",      instruction, 32'hA000_0002);

    fetch(32'h0);
    check_resp("f0", 32'hA000_0001, 1'b0);
    fetch(32'hC);
    check_resp("fC_past_count", HALT, 1'b1);
    fetch(32'h6);
    check_resp("f6_misalign", HALT, 1'b1);
    fetch(32'h400);
    check_resp("f400_range", HALT, 1'b1);
    fetch(32'h8);
    check_resp("f8_last", 32'hA000_0003, 1'b0);

    // Full store plus two overflowing writes
    load_en = 1'b1; tick();
    check("reload_clear", instruction, 32'd0);
    load_wr = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      load_data = 32'hB000_0000 + i;
      tick();
    end
    load_wr = 1'b0; load_en = 1'b0; tick();
    check("full_count", {23'd0, load_count}, 32'd256);
    check("full_ovf",   {31'd0, load_overflow}, 32'd1);
    fetch(32'h3FC);
    check_resp("f3FC", 32'hB000_00FF, 1'b0);
    fetch(32'h0);
    check_resp("f0_no_wrap", 32'hB000_0000, 1'b0);

    // Back-to-back fetches
    mem_activation = 1'b1; pc = 32'h0; tick();
    check_resp("bb0", 32'hB000_0000, 1'b0);
    pc = 32'h4; tick();
    check_resp("bb1", 32'hB000_0001, 1'b0);
    pc = 32'h8; tick();
    check_resp("bb2", 32'hB000_0002, 1'b0);
    mem_activation = 1'b0; tick();
    check("bb_pulse_end", {31'd0, instr_valid}, 32'd0);
    check("bb_hold",      instruction, 32'hB000_0002);

    // Reload and fetch in the same cycle: reload wins
    load_en = 1'b1; mem_activation = 1'b1; pc = 32'h4; tick();
    mem_activation = 1'b0;
    check("coll_valid", {31'd0, instr_valid}, 32'd0);
    check("coll_instr", instruction, 32'd0);
    check("coll_done",  {31'd0, load_done}, 32'd0);
    check("coll_ovf",   {31'd0, load_overflow}, 32'd0);

    // Fetch while loading is ignored
    fetch(32'h0);
    check("ldfetch_valid", {31'd0, instr_valid}, 32'd0);

    // Two writes, then asynchronous reset mid-load
    load_wr = 1'b1;
    load_data = 32'hC000_0001; tick();
    load_data = 32'hC000_0002; tick();
    #2 rst_l = 1'b0;
    #1;
    check("arst_count", {23'd0, load_count}, 32'd0);
    check("arst_done",  {31'd0, load_done}, 32'd0);
    load_wr = 1'b0; load_en = 1'b0;
    tick();
    rst_l = 1'b1;
    tick();
    fetch(32'h0);
    check("idle_fetch_valid", {31'd0, instr_valid}, 32'd0);
    check("idle_fetch_instr", instruction, 32'd0);

    // Empty load: every fetch is a halt
    load_en = 1'b1; tick();
    load_en = 1'b0; tick();
    check("empty_count", {23'd0, load_count}, 32'd0);
    fetch(32'h0);
    check_resp("empty_f0", HALT, 1'b1);

    // New load of one word, then a good fetch
    load_en = 1'b1; tick();
    load_wr = 1'b1; load_data = 32'hD000_0001; tick();
    load_wr = 1'b0; load_en = 1'b0; tick();
    check("new_count", {23'd0, load_count}, 32'd1);
    fetch(32'h0);
    check_resp("new_f0", 32'hD000_0001, 1'b0);
    fetch(32'h4);
    check_resp("new_f4", HALT, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
